// File: rtl/cart_ddr_bridge.sv
// Bridges the cartridge's level-held 16-bit MEM requests onto single-shot 32-bit DDR commands.
// Optional read buffer (one 32-bit word, tag and valid bit) is compiled in when CART_RDBUF_EN is defined.
module cart_ddr_bridge #(
    parameter logic [27:0] DDR_BASE = 28'h3000000,
    parameter int          TIMEOUT  = 1023
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [21:1] CART_A,
    input  logic [15:0] CART_DI,
    input  logic [1:0]  CART_WE,
    input  logic        CART_RD,
    output logic [15:0] CART_DO,
    output logic        CART_RDY,
    output logic [25:0] DDR_A,
    output logic [31:0] DDR_DO,
    output logic [3:0]  DDR_BE,
    output logic        DDR_RD,
    output logic        DDR_WE,
    input  logic        DDR_BUSY,
    input  logic [31:0] DDR_DI,
    input  logic        DDR_DRDY,
    output logic        ERR
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_HOLD
    } state_t;

    state_t           state;
    logic             a1_q;
    logic             wr_q;
    logic             stale;
    logic [CNT_W-1:0] cnt;

    logic        req_wr;
    logic        req_any;
    logic [25:0] req_addr;
    logic [3:0]  req_be;
    logic        rd_hit;
    logic        rd_accept;

    // CART_A[1] low selects the upper halfword of the DDR word
    function automatic logic [15:0] half_sel(input logic [31:0] w, input logic lo);
        return lo ? w[15:0] : w[31:16];
    endfunction

    assign req_wr    = |CART_WE;
    assign req_any   = req_wr | CART_RD;
    assign req_addr  = DDR_BASE[27:2] + {6'd0, CART_A[21:2]};
    assign req_be    = CART_A[1] ? {2'b00, CART_WE} : {CART_WE, 2'b00};
    assign rd_accept = (state == S_WAIT) && DDR_DRDY && !stale;

`ifdef CART_RDBUF_EN
    logic [31:0] buf_data;
    logic [25:0] buf_tag;
    logic        buf_vld;

    assign rd_hit = !req_wr && CART_RD && buf_vld && (buf_tag == req_addr);

    always_ff @(posedge CLK) begin
        if (rd_accept) begin
            buf_data <= DDR_DI;
            buf_tag  <= DDR_A;
        end
    end
`else
    assign rd_hit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            CART_DO  <= 16'hFFFF;
            CART_RDY <= 1'b0;
            DDR_A    <= '0;
            DDR_DO   <= '0;
            DDR_BE   <= '0;
            DDR_RD   <= 1'b0;
            DDR_WE   <= 1'b0;
            ERR      <= 1'b0;
            a1_q     <= 1'b0;
            wr_q     <= 1'b0;
            stale    <= 1'b0;
            cnt      <= '0;
`ifdef CART_RDBUF_EN
            buf_vld  <= 1'b0;
`endif
        end else begin
            DDR_RD   <= 1'b0;
            DDR_WE   <= 1'b0;
            CART_RDY <= 1'b0;
            // The first return after a timeout belongs to the abandoned read
            if (DDR_DRDY && stale)
                stale <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rd_hit) begin
`ifdef CART_RDBUF_EN
                        CART_DO <= half_sel(buf_data, CART_A[1]);
`endif
                        state <= S_DONE;
                    end else if (req_any) begin
                        a1_q   <= CART_A[1];
                        wr_q   <= req_wr;
                        DDR_A  <= req_addr;
                        DDR_DO <= {CART_DI, CART_DI};
                        DDR_BE <= req_be;
                        state  <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (!DDR_BUSY) begin
                        if (wr_q) begin
                            DDR_WE <= 1'b1;
`ifdef CART_RDBUF_EN
                            buf_vld <= 1'b0;
`endif
                            state  <= S_DONE;
                        end else begin
                            DDR_RD <= 1'b1;
                            cnt    <= '0;
                            state  <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (rd_accept) begin
                        CART_DO <= half_sel(DDR_DI, a1_q);
`ifdef CART_RDBUF_EN
                        buf_vld <= 1'b1;
`endif
                        state   <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        CART_DO <= 16'hFFFF;
                        ERR     <= 1'b1;
                        stale   <= 1'b1;
`ifdef CART_RDBUF_EN
                        buf_vld <= 1'b0;
`endif
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    CART_RDY <= 1'b1;
                    state    <= S_HOLD;
                end

                // Requests are level-held, so wait for release before sampling again
                S_HOLD: begin
                    if (!CART_RD && (CART_WE == 2'b00))
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_ddr_bridge.sv
// Bench for cart_ddr_bridge: vector table, randomized traffic against a transaction-level model, directed corner cases.
module tb_cart_ddr_bridge;

    localparam logic [27:0] BASE = 28'h3000000;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] cart_a;
    logic [15:0] cart_di;
    logic [1:0]  cart_we;
    logic        cart_rd;
    logic [15:0] cart_do;
    logic        cart_rdy;
    logic [25:0] ddr_a;
    logic [31:0] ddr_do;
    logic [3:0]  ddr_be;
    logic        ddr_rd;
    logic        ddr_we;
    logic        ddr_busy;
    logic [31:0] ddr_di;
    logic        ddr_drdy;
    logic        err;

    always #5 clk = ~clk;

    cart_ddr_bridge #(.DDR_BASE(BASE), .TIMEOUT(TMO)) dut (
        .CLK(clk), .RST(rst),
        .CART_A(cart_a), .CART_DI(cart_di), .CART_WE(cart_we), .CART_RD(cart_rd),
        .CART_DO(cart_do), .CART_RDY(cart_rdy),
        .DDR_A(ddr_a), .DDR_DO(ddr_do), .DDR_BE(ddr_be), .DDR_RD(ddr_rd), .DDR_WE(ddr_we),
        .DDR_BUSY(ddr_busy), .DDR_DI(ddr_di), .DDR_DRDY(ddr_drdy),
        .ERR(err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_rd_p = 0;
    int n_we_p = 0;
    int n_rdy_p = 0;

    always @(negedge clk) begin
        if (ddr_rd)   n_rd_p++;
        if (ddr_we)   n_we_p++;
        if (cart_rdy) n_rdy_p++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Transaction-level model state
    logic [15:0] m_cdo;
    bit          m_err;
    bit          m_stale;
    bit          m_bvld;
    logic [25:0] m_btag;
    logic [31:0] m_bword;

    function automatic logic [25:0] m_addr(input logic [20:0] a);
        logic [27:0] sum;
        sum = (BASE >> 2) + 28'(a >> 1);
        return sum[25:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [20:0] a, input logic [1:0] we);
        logic [3:0] w4;
        w4 = 4'(we);
        return a[0] ? w4 : 4'(w4 * 4'd4);
    endfunction

    function automatic logic [15:0] m_half(input logic [31:0] w, input logic lo);
        logic [31:0] s;
        s = lo ? w : (w >> 16);
        return s[15:0];
    endfunction

    function automatic bit m_hit(input bit wr, input logic [20:0] a);
`ifdef CART_RDBUF_EN
        return !wr && m_bvld && (m_btag == m_addr(a));
`else
        return 1'b0 & wr & a[0];
`endif
    endfunction

    task automatic tb_reset_model();
        m_cdo   = 16'hFFFF;
        m_err   = 0;
        m_stale = 0;
        m_bvld  = 0;
        m_btag  = '0;
        m_bword = '0;
    endtask

    task automatic xact(input string nm, input bit wr, input logic [20:0] a, input logic [15:0] di,
                        input logic [1:0] we, input int busy_n, input int junk_dly, input int drdy_dly,
                        input logic [31:0] word, input logic [25:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_do, input logic [15:0] e_cdo, input bit e_tmo);
        int rd0, we0, rdy0, issued, rdy_at, e_issue, e_rdy;
        bit hit;
        hit  = m_hit(wr, a);
        rd0  = n_rd_p;
        we0  = n_we_p;
        rdy0 = n_rdy_p;
        cart_a   = a;
        cart_di  = di;
        cart_we  = wr ? we : 2'b00;
        cart_rd  = !wr;
        ddr_busy = (busy_n > 0);
        ddr_drdy = 1'b0;
        issued = -1;
        rdy_at = -1;
        for (int cyc = 1; cyc <= 60 + TMO; cyc++) begin
            @(posedge clk); #1;
            if (issued < 0 && (ddr_rd || ddr_we)) begin
                issued = cyc;
                check({nm, ".ddr_a"}, 32'(ddr_a), 32'(e_addr));
                check({nm, ".ddr_be"}, 32'(ddr_be), 32'(e_be));
                if (wr) check({nm, ".ddr_do"}, ddr_do, e_do);
            end
            if (cart_rdy) begin
                rdy_at = cyc;
                break;
            end
            ddr_busy = (cyc < busy_n);
            ddr_drdy = 1'b0;
            if (!wr && issued >= 0) begin
                if (junk_dly >= 0 && cyc == issued + junk_dly) begin
                    ddr_drdy = 1'b1;
                    ddr_di   = ~word;
                end
                if (drdy_dly >= 0 && cyc == issued + drdy_dly) begin
                    ddr_drdy = 1'b1;
                    ddr_di   = word;
                end
            end
        end
        e_issue = hit ? -1 : ((busy_n + 1 > 2) ? busy_n + 1 : 2);
        e_rdy   = hit ? 2 : wr ? e_issue + 1 : e_tmo ? e_issue + TMO + 1 : e_issue + drdy_dly + 2;
        check({nm, ".issue_cyc"}, issued, e_issue);
        check({nm, ".rdy_cyc"}, rdy_at, e_rdy);
        check({nm, ".cart_do"}, 32'(cart_do), 32'(e_cdo));
        cart_rd  = 1'b0;
        cart_we  = 2'b00;
        ddr_drdy = 1'b0;
        ddr_busy = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({nm, ".n_ddr_rd"}, n_rd_p - rd0, (!wr && !hit) ? 1 : 0);
        check({nm, ".n_ddr_we"}, n_we_p - we0, wr ? 1 : 0);
        check({nm, ".n_rdy"}, n_rdy_p - rdy0, 1);
        // Model update
        if (wr) begin
            m_bvld = 0;
        end else if (hit) begin
            m_cdo = m_half(m_bword, a[0]);
        end else if (e_tmo) begin
            m_cdo = 16'hFFFF; m_err = 1; m_stale = 1; m_bvld = 0;
        end else begin
            m_cdo = m_half(word, a[0]);
            m_stale = 0;
            m_bvld = 1; m_btag = m_addr(a); m_bword = word;
        end
        check({nm, ".err"}, 32'(err), 32'(m_err));
        check({nm, ".model_cdo"}, 32'(cart_do), 32'(m_cdo));
    endtask

    task automatic rand_xact(input string nm, input bit wr, input logic [20:0] a, input int dly,
                             input logic [31:0] word, input bit tmo, input int junk);
        logic [15:0] di;
        logic [1:0]  we;
        logic [15:0] e_cdo;
        int          busy_n;
        di     = 16'($urandom);
        we     = 2'($urandom_range(1, 3));
        busy_n = $urandom_range(0, 3);
        if (wr)               e_cdo = m_cdo;
        else if (m_hit(wr, a)) e_cdo = m_half(m_bword, a[0]);
        else if (tmo)         e_cdo = 16'hFFFF;
        else                  e_cdo = m_half(word, a[0]);
        xact(nm, wr, a, di, we, busy_n, junk, dly, word, m_addr(a),
             wr ? m_be(a, we) : 4'h0, 32'(di) * 32'h0001_0001, e_cdo, tmo);
    endtask

    typedef struct {
        bit          wr;
        logic [20:0] a;
        logic [15:0] di;
        logic [1:0]  we;
        int          busy_n;
        int          drdy_dly;
        logic [31:0] word;
        logic [25:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_do;
        logic [15:0] e_cdo;
    } vec_t;

    vec_t tab[9];

    initial begin
        int rdy0;
        tab[0] = '{1, 21'h000001, 16'h1234, 2'b11, 0,  0, 32'h0,         26'h0C00000, 4'b0011, 32'h12341234, 16'hFFFF};
        tab[1] = '{0, 21'h000000, 16'h0,    2'b00, 0,  5, 32'hAABBCCDD,  26'h0C00000, 4'b0000, 32'h0,        16'hAABB};
        tab[2] = '{0, 21'h000001, 16'h0,    2'b00, 0,  3, 32'hAABBCCDD,  26'h0C00000, 4'b0000, 32'h0,        16'hCCDD};
        tab[3] = '{1, 21'h000000, 16'hBEEF, 2'b01, 0,  0, 32'h0,         26'h0C00000, 4'b0100, 32'hBEEFBEEF, 16'hCCDD};
        tab[4] = '{1, 21'h1FFFFF, 16'h5A5A, 2'b10, 0,  0, 32'h0,         26'h0CFFFFF, 4'b0010, 32'h5A5A5A5A, 16'hCCDD};
        tab[5] = '{0, 21'h000006, 16'h0,    2'b00, 10, 2, 32'h12345678,  26'h0C00003, 4'b0000, 32'h0,        16'h1234};
        tab[6] = '{0, 21'h000007, 16'h0,    2'b00, 0,  0, 32'h12345678,  26'h0C00003, 4'b0000, 32'h0,        16'h5678};
        tab[7] = '{1, 21'h000003, 16'h0001, 2'b10, 0,  0, 32'h0,         26'h0C00001, 4'b0010, 32'h00010001, 16'h5678};
        tab[8] = '{0, 21'h000000, 16'h0,    2'b00, 2,  1, 32'h0F0FF0F0,  26'h0C00000, 4'b0000, 32'h0,        16'h0F0F};

        rst = 1'b1;
        cart_a = '0; cart_di = '0; cart_we = '0; cart_rd = 1'b0;
        ddr_busy = 1'b0; ddr_di = '0; ddr_drdy = 1'b0;
        tb_reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.cart_do", 32'(cart_do), 32'hFFFF);
        check("rst.cart_rdy", 32'(cart_rdy), 0);
        check("rst.ddr_a", 32'(ddr_a), 0);
        check("rst.ddr_do", ddr_do, 0);
        check("rst.ddr_be", 32'(ddr_be), 0);
        check("rst.ddr_cmd", 32'({ddr_rd, ddr_we}), 0);
        check("rst.err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            xact($sformatf("vec%0d", i), tab[i].wr, tab[i].a, tab[i].di, tab[i].we, tab[i].busy_n, -1,
                 tab[i].drdy_dly, tab[i].word, tab[i].e_addr, tab[i].e_be, tab[i].e_do, tab[i].e_cdo, 0);

        for (int i = 0; i < 40; i++) begin
            logic [20:0] a;
            a = ($urandom_range(0, 1) != 0) ? 21'($urandom_range(0, 7)) : 21'($urandom);
            rand_xact($sformatf("rnd%0d", i), $urandom_range(0, 1) != 0, a,
                      $urandom_range(0, 5), $urandom, 0, -1);
        end

        // Timeout, then a late return arriving while idle
        rand_xact("tmo1", 0, 21'h000010, -1, 32'h0, 1, -1);
        rdy0 = n_rdy_p;
        ddr_drdy = 1'b1; ddr_di = 32'hDEADBEEF;
        @(posedge clk); #1;
        ddr_drdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_stale = 0;
        check("late_idle.n_rdy", n_rdy_p - rdy0, 0);
        check("late_idle.cart_do", 32'(cart_do), 32'hFFFF);
        rand_xact("after_tmo1", 0, 21'h000010, 2, 32'h11223344, 0, -1);

        // Timeout, then the late return lands inside the next read's wait
        rand_xact("tmo2", 0, 21'h000012, -1, 32'h0, 1, -1);
        rand_xact("after_tmo2", 0, 21'h000013, 4, 32'h55667788, 0, 1);

        // Reset in the middle of a read wait
        rdy0 = n_rdy_p;
        cart_a = 21'h000020; cart_rd = 1'b1;
        for (int i = 0; i < 10 && !ddr_rd; i++) begin
            @(posedge clk); #1;
        end
        check("midrst.ddr_rd_seen", 32'(ddr_rd), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.cart_do", 32'(cart_do), 32'hFFFF);
        check("midrst.err", 32'(err), 0);
        check("midrst.ddr_a", 32'(ddr_a), 0);
        check("midrst.ddr_be", 32'(ddr_be), 0);
        check("midrst.cmd_rdy", 32'({ddr_rd, ddr_we, cart_rdy}), 0);
        @(negedge clk);
        rst = 1'b0;
        cart_rd = 1'b0;
        tb_reset_model();
        ddr_drdy = 1'b1; ddr_di = 32'hCAFEF00D;
        @(posedge clk); #1;
        ddr_drdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst.n_rdy", n_rdy_p - rdy0, 0);
        check("midrst.cart_do_after", 32'(cart_do), 32'hFFFF);
        rand_xact("after_rst", 0, 21'h000020, 1, 32'h9ABCDEF0, 0, -1);
        rand_xact("after_rst_wr", 1, 21'h000021, 0, 32'h0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
